hazard_ctrl: RTL and testbench

//  Parametrised hazard/stall controller for the 5-stage pipeline; next generation of the combinational ID/IF stall logic.

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Decode-to-hazard-controller bundle: ID instruction fields in, stall and forwarding controls out.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int DEPTH = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [REG_W-1:0] id_rd;
  logic             id_regwr;
  logic             id_is_load;
  logic             id_is_branch;
  logic             if_stall;
  logic             id_stall;
  logic [SEL_W-1:0] fwd_rs_sel;
  logic [SEL_W-1:0] fwd_rt_sel;
  logic             busy;

  modport master (
    output flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_regwr, id_is_load, id_is_branch,
    input  if_stall, id_stall, fwd_rs_sel, fwd_rt_sel, busy
  );

  modport slave (
    input  flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_regwr, id_is_load, id_is_branch,
    output if_stall, id_stall, fwd_rs_sel, fwd_rt_sel, busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RAW hazard / stall controller: shadow scoreboard of in-flight destinations (EX..WB),
// forwarding selects, and a counter FSM that holds IF for a fixed branch penalty.
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int DEPTH      = 3,
  parameter int FWD_EN     = 1,
  parameter int BR_PENALTY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam logic [3:0] BCNT_LOAD = 4'(BR_PENALTY - 1);

  typedef enum logic [0:0] {S_IDLE, S_BR} state_t;

  // Scoreboard: index 0 is EX, DEPTH-1 is the oldest tracked stage
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_regwr;
  logic [DEPTH-1:0] r_load;
  logic [REG_W-1:0] r_rd [DEPTH];

  state_t           r_state;
  logic [3:0]       r_bcnt;

  logic             w_rs_any, w_rt_any;
  logic             w_rs_hz, w_rt_hz;
  logic [SEL_W-1:0] w_rs_sel, w_rt_sel;
  logic             w_id_stall;
  logic             w_accept;
  logic             w_take;

  function automatic logic f_match(input logic used, input logic v, input logic wr,
                                   input logic [REG_W-1:0] rd, input logic [REG_W-1:0] src);
    return used && v && wr && (rd == src) && (src != '0);
  endfunction

  // Descending scan so the youngest (lowest index) match overwrites older ones
  always_comb begin
    w_rs_any = 1'b0;
    w_rt_any = 1'b0;
    w_rs_sel = '0;
    w_rt_sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (f_match(bus.id_rs_used, r_v[k], r_regwr[k], r_rd[k], bus.id_rs)) begin
        w_rs_any = 1'b1;
        w_rs_sel = SEL_W'(k + 1);
      end
      if (f_match(bus.id_rt_used, r_v[k], r_regwr[k], r_rd[k], bus.id_rt)) begin
        w_rt_any = 1'b1;
        w_rt_sel = SEL_W'(k + 1);
      end
    end
    if (FWD_EN != 0) begin
      w_rs_hz = (w_rs_sel == SEL_W'(1)) && r_load[0];
      w_rt_hz = (w_rt_sel == SEL_W'(1)) && r_load[0];
    end else begin
      w_rs_hz = w_rs_any;
      w_rt_hz = w_rt_any;
    end
  end

  assign w_id_stall = bus.id_valid && (w_rs_hz || w_rt_hz);
  assign w_accept   = bus.id_valid && bus.id_is_branch && !w_id_stall;
  assign w_take     = bus.id_valid && !w_id_stall;

  assign bus.id_stall   = w_id_stall;
  assign bus.if_stall   = w_id_stall || w_accept || (r_bcnt != 4'd0);
  assign bus.fwd_rs_sel = (FWD_EN != 0 && bus.id_valid && !w_rs_hz) ? w_rs_sel : '0;
  assign bus.fwd_rt_sel = (FWD_EN != 0 && bus.id_valid && !w_rt_hz) ? w_rt_sel : '0;
  assign bus.busy       = (|r_v) || (r_bcnt != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (bus.flush) begin
      r_v <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) r_v[i] <= r_v[i-1];
      r_v[0] <= w_take;
    end
  end

  // Payload fields are qualified by r_v, so they carry no reset
  always_ff @(posedge clk) begin
    for (int i = DEPTH - 1; i > 0; i--) begin
      r_rd[i]    <= r_rd[i-1];
      r_regwr[i] <= r_regwr[i-1];
      r_load[i]  <= r_load[i-1];
    end
    r_rd[0]    <= bus.id_rd;
    r_regwr[0] <= bus.id_regwr;
    r_load[0]  <= bus.id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bcnt  <= 4'd0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_bcnt  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bcnt  <= BCNT_LOAD;
            r_state <= (BR_PENALTY > 1) ? S_BR : S_IDLE;
          end
        end
        S_BR: begin
          if (w_accept) begin
            r_bcnt <= BCNT_LOAD;
          end else if (r_bcnt <= 4'd1) begin
            r_bcnt  <= 4'd0;
            r_state <= S_IDLE;
          end else begin
            r_bcnt <= r_bcnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_bcnt  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: forwarding instance (A) and stall-only, 3-cycle-branch instance (B)
// share stimulus; expected responses are queued and checked by a separate monitor.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(5), .DEPTH(3)) ifa ();
  hazard_ctrl_if #(.REG_W(5), .DEPTH(3)) ifb ();

  hazard_ctrl #(.REG_W(5), .DEPTH(3), .FWD_EN(1), .BR_PENALTY(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  hazard_ctrl #(.REG_W(5), .DEPTH(3), .FWD_EN(0), .BR_PENALTY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  typedef struct {
    int         dut;
    string      name;
    logic       ifs;
    logic       ids;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic setid(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic br);
    ifa.id_valid = v;   ifb.id_valid = v;
    ifa.id_rs = rs;     ifb.id_rs = rs;
    ifa.id_rt = rt;     ifb.id_rt = rt;
    ifa.id_rs_used = rsu; ifb.id_rs_used = rsu;
    ifa.id_rt_used = rtu; ifb.id_rt_used = rtu;
    ifa.id_rd = rd;     ifb.id_rd = rd;
    ifa.id_regwr = wr;  ifb.id_regwr = wr;
    ifa.id_is_load = ld; ifb.id_is_load = ld;
    ifa.id_is_branch = br; ifb.id_is_branch = br;
  endtask

  task automatic setflush(input logic f);
    ifa.flush = f;
    ifb.flush = f;
  endtask

  task automatic ex(input int dut, input string nm, input logic ifs, input logic ids,
                    input logic [1:0] rs, input logic [1:0] rt, input logic busy);
    exp_t e;
    e.dut = dut; e.name = nm; e.ifs = ifs; e.ids = ids;
    e.rs = rs; e.rt = rt; e.busy = busy;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  // Monitor: samples mid-cycle, and also right after an asynchronous reset edge
  initial begin
    exp_t e;
    logic       a_ifs, a_ids, a_busy;
    logic [1:0] a_rs, a_rt;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut == 0) begin
          a_ifs = ifa.if_stall; a_ids = ifa.id_stall; a_rs = ifa.fwd_rs_sel;
          a_rt = ifa.fwd_rt_sel; a_busy = ifa.busy;
        end else begin
          a_ifs = ifb.if_stall; a_ids = ifb.id_stall; a_rs = ifb.fwd_rs_sel;
          a_rt = ifb.fwd_rt_sel; a_busy = ifb.busy;
        end
        total++;
        if (a_ifs !== e.ifs || a_ids !== e.ids || a_rs !== e.rs ||
            a_rt !== e.rt || a_busy !== e.busy) begin
          bad++;
          $display("FAIL %s dut%0d: got ifs=%b ids=%b rs=%0d rt=%0d busy=%b, required ifs=%b ids=%b rs=%0d rt=%0d busy=%b",
                   e.name, e.dut, a_ifs, a_ids, a_rs, a_rt, a_busy,
                   e.ifs, e.ids, e.rs, e.rt, e.busy);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    setflush(0);
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // Reset state
    ex(0, "reset", 0, 0, 0, 0, 0);
    ex(1, "reset", 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // add r3 then sub r4,r3,r1 held in ID
    setid(1, 1, 2, 1, 1, 3, 1, 0, 0);
    ex(0, "add_r3", 0, 0, 0, 0, 0);
    ex(1, "add_r3", 0, 0, 0, 0, 0);
    tick();
    setid(1, 3, 1, 1, 1, 4, 1, 0, 0);
    ex(0, "fwd_ex", 0, 0, 1, 0, 1);
    ex(1, "raw_ex", 1, 1, 0, 0, 1);
    tick();
    ex(0, "fwd_mem", 0, 0, 2, 0, 1);
    ex(1, "raw_mem", 1, 1, 0, 0, 1);
    tick();
    ex(0, "fwd_wb", 0, 0, 3, 0, 1);
    ex(1, "raw_wb", 1, 1, 0, 0, 1);
    tick();
    ex(0, "no_match", 0, 0, 0, 0, 1);
    ex(1, "raw_clear", 0, 0, 0, 0, 0);
    tick();
    drain();

    // lw r5 then add r6,r5,r5
    setid(1, 1, 0, 1, 0, 5, 1, 1, 0);
    ex(0, "lw_r5", 0, 0, 0, 0, 0);
    ex(1, "lw_r5", 0, 0, 0, 0, 0);
    tick();
    setid(1, 5, 5, 1, 1, 6, 1, 0, 0);
    ex(0, "load_use", 1, 1, 0, 0, 1);
    ex(1, "load_use", 1, 1, 0, 0, 1);
    tick();
    ex(0, "load_fwd_mem", 0, 0, 2, 2, 1);
    ex(1, "load_raw_mem", 1, 1, 0, 0, 1);
    tick();
    drain();

    // write r0 then read r0
    setid(1, 1, 2, 1, 1, 0, 1, 0, 0);
    ex(0, "wr_r0", 0, 0, 0, 0, 0);
    ex(1, "wr_r0", 0, 0, 0, 0, 0);
    tick();
    setid(1, 0, 0, 1, 1, 7, 1, 0, 0);
    ex(0, "rd_r0", 0, 0, 0, 0, 1);
    ex(1, "rd_r0", 0, 0, 0, 0, 1);
    tick();
    drain();

    // Accepted branch: A holds IF 2 cycles, B 3 cycles
    setid(1, 1, 2, 1, 1, 0, 0, 0, 1);
    ex(0, "br_accept", 1, 0, 0, 0, 0);
    ex(1, "br_accept", 1, 0, 0, 0, 0);
    tick();
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(0, "br_cnt1", 1, 0, 0, 0, 1);
    ex(1, "br_cnt2", 1, 0, 0, 0, 1);
    tick();
    ex(0, "br_done", 0, 0, 0, 0, 1);
    ex(1, "br_cnt1", 1, 0, 0, 0, 1);
    tick();
    ex(0, "br_after", 0, 0, 0, 0, 1);
    ex(1, "br_done", 0, 0, 0, 0, 1);
    tick();
    drain();

    // lw r5 then beq r5,r0: 1 load-use stall + 2 branch cycles on A
    setid(1, 1, 0, 1, 0, 5, 1, 1, 0);
    ex(0, "lwbr_lw", 0, 0, 0, 0, 0);
    tick();
    setid(1, 5, 0, 1, 1, 0, 0, 0, 1);
    ex(0, "lwbr_stall", 1, 1, 0, 0, 1);
    tick();
    ex(0, "lwbr_accept", 1, 0, 2, 0, 1);
    tick();
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(0, "lwbr_cnt", 1, 0, 0, 0, 1);
    tick();
    ex(0, "lwbr_done", 0, 0, 0, 0, 1);
    tick();
    drain();

    // flush in the middle of a branch penalty
    setid(1, 1, 2, 1, 1, 0, 0, 0, 1);
    ex(0, "fl_accept", 1, 0, 0, 0, 0);
    ex(1, "fl_accept", 1, 0, 0, 0, 0);
    tick();
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0);
    setflush(1);
    ex(0, "fl_cycle", 1, 0, 0, 0, 1);
    ex(1, "fl_cycle", 1, 0, 0, 0, 1);
    tick();
    setflush(0);
    ex(0, "fl_cleared", 0, 0, 0, 0, 0);
    ex(1, "fl_cleared", 0, 0, 0, 0, 0);
    tick();
    drain();

    // async reset in the middle of a load-use stall
    setid(1, 1, 0, 1, 0, 5, 1, 1, 0);
    ex(0, "ar_lw", 0, 0, 0, 0, 0);
    ex(1, "ar_lw", 0, 0, 0, 0, 0);
    tick();
    setid(1, 5, 5, 1, 1, 6, 1, 0, 0);
    ex(0, "ar_stall", 1, 1, 0, 0, 1);
    ex(1, "ar_stall", 1, 1, 0, 0, 1);
    @(negedge clk);
    #2;
    ex(0, "ar_reset", 0, 0, 0, 0, 0);
    ex(1, "ar_reset", 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending: got %0d unchecked expectations, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
